sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of storage words; power of two, at least 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full threshold in words; range 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, meaning almost_empty threshold in words; range 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port w_en, input, 1, meaning write request.
REQ-009 SHALL have port r_en, input, 1, meaning read request.
REQ-010 SHALL have port data_in, input, DATA_WIDTH, meaning write data.
REQ-011 SHALL have port data_out, output, DATA_WIDTH, meaning read data.
REQ-012 SHALL have ports full and empty, output, 1 each, meaning count==DEPTH and count==0 respectively.
REQ-013 SHALL have ports almost_full and almost_empty, output, 1 each, meaning count>=AF_LEVEL and count<=AE_LEVEL respectively.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, meaning current occupancy 0..DEPTH.
REQ-015 SHALL have ports overflow and underflow, output, 1 each, meaning one-cycle error pulses.

Function
REQ-016 SHALL store exactly DEPTH words; full asserts only when all DEPTH locations hold unread data.
REQ-017 SHALL use read and write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes wrap, the low bits index memory, and both wrap naturally modulo 2*DEPTH.
REQ-018 SHALL accept a read when r_en=1 and empty=0.
REQ-019 SHALL accept a write when w_en=1 and full=0, or when w_en=1 and full=1 and a read is accepted in the same cycle.
REQ-020 SHALL, on a simultaneous w_en and r_en with empty=1, accept the write, reject the read, and leave count incremented by 1.
REQ-021 SHALL update count on the edge after an access: +1 write only, -1 read only, unchanged for both or neither.
REQ-022 SHALL derive full, empty, almost_full and almost_empty from registered count/pointer state only, with no combinational path from w_en or r_en.
REQ-023 SHALL, when FWFT=0, load data_out with the head word on the edge that accepts a read, and hold data_out when no read is accepted.
REQ-024 SHALL, when FWFT=1, drive data_out with the head word whenever empty=0 and with 0 when empty=1; an accepted read advances data_out to the next word on the following edge.
REQ-025 SHALL, when FWFT=1, present a word written into an empty FIFO on data_out in the cycle after the write edge, coincident with empty deasserting.
REQ-026 SHALL assert overflow for exactly one cycle, on the edge following a cycle with w_en=1 and the write rejected; FIFO contents and pointers are unchanged.
REQ-027 SHALL assert underflow for exactly one cycle, on the edge following a cycle with r_en=1 and the read rejected; FIFO contents, pointers and data_out are unchanged.
REQ-028 SHALL preserve write order exactly across pointer wrap-around.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, clear both pointers and count to 0, data_out to 0, and overflow and underflow to 0.
REQ-030 SHALL, after reset, present empty=1, full=0, almost_empty=1, and almost_full=0.
REQ-031 SHALL give rst priority over w_en and r_en in the same cycle; a reset mid-operation discards all stored data.
REQ-032 SHALL NOT reset memory contents.

Verification (DEPTH=16, DATA_WIDTH=8, AF_LEVEL=14, AE_LEVEL=2)
REQ-033 SHALL cover: reset, then write 0x00..0x0F -> count reaches 16, full=1, almost_full asserts on the edge count becomes 14, almost_empty deasserts on the edge count becomes 3.
REQ-034 SHALL cover: when full, w_en alone with 0xAA -> overflow pulses one cycle, count stays 16, and a subsequent full drain returns 0x00..0x0F in order.
REQ-035 SHALL cover: when full, w_en=1 with 0x55 and r_en=1 simultaneously -> both accepted, count stays 16, full stays 1, and 0x55 is the last word read.
REQ-036 SHALL cover: when empty, r_en=1 and w_en=1 with 0x33 -> underflow pulses, count becomes 1; with FWFT=1, data_out=0x33 on the next cycle.
REQ-037 SHALL cover: 40 interleaved random writes and reads -> output order matches a scoreboard across pointer wrap, and count always equals writes minus reads.
REQ-038 SHALL cover: rst asserted with count=9 and w_en=r_en=1 -> next cycle count=0, empty=1, data_out=0, and no overflow or underflow.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, registered full/empty/almost flags and
// one-cycle overflow/underflow pulses. Read port is registered (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo_flags #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE_CNT   = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] count_reg;
    logic [PW-1:0] count_next;

    logic full_reg;
    logic empty_reg;
    logic almost_full_reg;
    logic almost_empty_reg;
    logic overflow_reg;
    logic underflow_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;

    logic rd_acc;
    logic wr_acc;

    // Acceptance uses only registered flags; a full FIFO still takes a write
    // when a read frees the head slot in the same cycle.
    assign rd_acc = r_en && !empty_reg;
    assign wr_acc = w_en && (!full_reg || rd_acc);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + ONE_CNT;
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + ONE_CNT;
        end
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + ONE_CNT;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            full_reg         <= (count_next == DEPTH_CNT);
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= AF_CNT);
            almost_empty_reg <= (count_next <= AE_CNT);
            overflow_reg     <= w_en && !wr_acc;
            underflow_reg    <= r_en && !rd_acc;
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_reg[AW-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            // Read-first: on a full read+write the head word leaves before being overwritten.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_reg <= '0;
                end else if (rd_acc) begin
                    data_out_reg <= mem[rd_ptr_reg[AW-1:0]];
                end
            end
        end else begin : g_fwft_read
            logic [AW-1:0] head_addr;
            logic          head_bypass;

            // The output register tracks the head after this edge; a word written
            // into the new head slot this cycle is not in memory yet, so forward it.
            assign head_addr   = rd_ptr_next[AW-1:0];
            assign head_bypass = wr_acc && (wr_ptr_reg[AW-1:0] == head_addr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_reg <= '0;
                end else if (count_next == '0) begin
                    data_out_reg <= '0;
                end else if (head_bypass) begin
                    data_out_reg <= data_in;
                end else begin
                    data_out_reg <= mem[head_addr];
                end
            end
        end
    endgenerate

    assign data_out     = data_out_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a registered-read and a FWFT instance with identical stimulus and checks
// both against a queue-based reference model after every clock edge.
module tb_sync_fifo_flags;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout_0, dout_1;
    logic          full_0, empty_0, af_0, ae_0, ovf_0, unf_0;
    logic          full_1, empty_1, af_1, ae_1, ovf_1, unf_1;
    logic [4:0]    count_0, count_1;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    byte unsigned  q[$];
    logic [DW-1:0] m_dout0 = '0;
    bit            m_ovf = 0;
    bit            m_unf = 0;
    int            wr_total = 0;
    int            rd_total = 0;

    sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(dout_0), .full(full_0), .empty(empty_0),
        .almost_full(af_0), .almost_empty(ae_0), .count(count_0),
        .overflow(ovf_0), .underflow(unf_0)
    );

    sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(dout_1), .full(full_1), .empty(empty_1),
        .almost_full(af_1), .almost_empty(ae_1), .count(count_1),
        .overflow(ovf_1), .underflow(unf_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_head;
        int          sz;
        sz       = q.size();
        exp_head = (sz != 0) ? 32'(q[0]) : 32'd0;
        check("count0", count_0, sz);
        check("count1", count_1, sz);
        check("balance", count_0, wr_total - rd_total);
        check("full0", full_0, sz == DEPTH);
        check("full1", full_1, sz == DEPTH);
        check("empty0", empty_0, sz == 0);
        check("empty1", empty_1, sz == 0);
        check("afull0", af_0, sz >= AF);
        check("afull1", af_1, sz >= AF);
        check("aempty0", ae_0, sz <= AE);
        check("aempty1", ae_1, sz <= AE);
        check("ovf0", ovf_0, m_ovf);
        check("ovf1", ovf_1, m_ovf);
        check("unf0", unf_0, m_unf);
        check("unf1", unf_1, m_unf);
        check("dout_std", dout_0, m_dout0);
        check("dout_fwft", dout_1, exp_head);
    endtask

    // One clock of stimulus: model is advanced from the pre-edge state, DUTs sampled 1ns after the edge.
    task automatic step(input bit r_st, input bit w, input bit r, input logic [DW-1:0] d);
        bit f, e, rd_ok, wr_ok;
        rst = r_st; w_en = w; r_en = r; data_in = d;
        if (r_st) begin
            q.delete();
            m_dout0 = '0; m_ovf = 0; m_unf = 0;
            wr_total = 0; rd_total = 0;
        end else begin
            f     = (q.size() == DEPTH);
            e     = (q.size() == 0);
            rd_ok = r && !e;
            wr_ok = w && (!f || rd_ok);
            if (rd_ok) begin
                m_dout0 = q.pop_front();
                rd_total++;
            end
            if (wr_ok) begin
                q.push_back(d);
                wr_total++;
            end
            m_ovf = w && !wr_ok;
            m_unf = r && !rd_ok;
        end
        @(posedge clk);
        #1;
        step_no++;
        $display("step %0d rst=%0b w=%0b r=%0b din=%02h count=%0d dout_std=%02h dout_fwft=%02h ovf=%0b unf=%0b",
                 step_no, r_st, w, r, d, count_0, dout_0, dout_1, ovf_0, unf_0);
        check_all();
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);

        // Fill 0x00..0x0F; flag thresholds checked on every edge by the model
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
        check("filled_full", full_0, 1);

        // Overflow while full, then drain in order
        step(0, 1, 0, 8'hAA);
        check("ovf_pulse", ovf_0, 1);
        step(0, 0, 0, 8'h00);
        check("ovf_cleared", ovf_0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 8'h00);
            check("drain_order", dout_0, i);
        end

        // Simultaneous read+write while full
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(i));
        step(0, 1, 1, 8'h55);
        check("rw_full_count", count_0, DEPTH);
        check("rw_full_flag", full_0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);
        check("last_word_55", dout_0, 8'h55);

        // Read+write while empty
        step(0, 1, 1, 8'h33);
        check("empty_rw_unf", unf_0, 1);
        check("empty_rw_cnt", count_0, 1);
        check("fwft_33", dout_1, 8'h33);
        step(0, 0, 1, 8'h00);
        check("std_33", dout_0, 8'h33);

        // Random interleaved traffic
        for (int i = 0; i < 40; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Reset with 9 words held and both requests active
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, 0, 1, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 8'(8'hC0 + i));
        check("pre_rst_cnt", count_0, 9);
        step(1, 1, 1, 8'hEE);
        check("rst_cnt", count_0, 0);
        check("rst_empty", empty_0, 1);
        check("rst_dout", dout_1, 0);
        step(0, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
